i2c_cfg_sequencer: RTL and testbench
====================================

I2C_CFG_SEQUENCER -- requirements
Module: i2c_cfg_sequencer

Interface
REQ-001 Parameter CLK_FREQ, 25_000_000, system clock frequency in Hz.
REQ-002 Parameter I2C_FREQ, 10_000, I2C control-clock frequency in Hz.
REQ-003 Parameter LUT_SIZE, 6, number of LUT entries, 1..255.
REQ-004 Parameter READ_COUNT, 2, leading entries issued as reads; 0..LUT_SIZE.
REQ-005 Parameter SLAVE_ADDR, 8'h42, 8-bit device write address placed in oI2C_WDATA[23:16].
REQ-006 Parameter MAX_RETRY, 3, retries per entry after the first attempt.
REQ-007 Port iCLK in 1: system clock; reset iRST_N, asynchronous, active-low; clock iCLK.
REQ-008 Port iRST_N in 1: asynchronous active-low reset.
REQ-009 Port iSTART in 1: single-cycle restart request.
REQ-010 Port LUT_INDEX out 8: current entry index.
REQ-011 Port iLUT_DATA in 16: {sub-address, data} for LUT_INDEX.
REQ-012 Ports: oI2C_CLK out 1 (engine work clock); oI2C_EN out 1 (engine enable strobe); oI2C_WDATA out 24; oI2C_GO out 1; oI2C_WR out 1 (1 = write); iI2C_END in 1; iI2C_ACK in 1 (0 = acked); iI2C_RDATA in 8.
REQ-013 Ports: Config_Done out 1; oCFG_ERR out 1; oERR_INDEX out 8; oRDATA out 8; oRDATA_VALID out 1 (one-cycle pulse).

Function
REQ-014 The block SHALL divide iCLK by (CLK_FREQ/I2C_FREQ)/2+1 per half-period to toggle oI2C_CLK.
REQ-015 oI2C_EN SHALL pulse for one iCLK cycle two cycles after each oI2C_CLK falling edge.
REQ-016 FSM transitions SHALL occur only on oI2C_EN cycles, except in DELAY, which uses a 1 ms tick derived from CLK_FREQ/1000.
REQ-017 States SHALL be IDLE, ISSUE, WAIT, NEXT, DELAY, VRFY_ISSUE, VRFY_WAIT, DONE, ERROR.
REQ-018 After reset the FSM SHALL leave IDLE automatically on the first oI2C_EN.
REQ-019 IDLE->ISSUE if LUT_INDEX<LUT_SIZE, otherwise IDLE->DONE.
REQ-020 In ISSUE with sub-address 8'hFF and LUT_INDEX>=READ_COUNT, the block SHALL enter DELAY, wait iLUT_DATA[7:0] ms, then go to NEXT, with no bus transaction; a value of 0 SHALL go to NEXT directly.
REQ-021 Otherwise ISSUE SHALL assert oI2C_GO, drive oI2C_WR=(LUT_INDEX>=READ_COUNT) and oI2C_WDATA={SLAVE_ADDR,iLUT_DATA}, and move to WAIT once iI2C_END=0.
REQ-022 In WAIT, on iI2C_END=1 the block SHALL deassert oI2C_GO and oI2C_WR, then evaluate the ACK.
REQ-023 If iI2C_ACK=0, the FSM SHALL go to NEXT, or to VRFY_ISSUE for a write when verify is compiled in.
REQ-024 If iI2C_ACK=1 (NACK), the retry counter SHALL increment and the FSM SHALL return to ISSUE; when the counter exceeds MAX_RETRY the FSM SHALL go to ERROR instead.
REQ-025 A completed read SHALL load oRDATA with iI2C_RDATA and pulse oRDATA_VALID in the same cycle.
REQ-026 NEXT SHALL increment LUT_INDEX, clear the retry counter, and return to IDLE.
REQ-027 DONE SHALL assert Config_Done=1 and hold LUT_INDEX.
REQ-028 ERROR SHALL assert oCFG_ERR=1, latch oERR_INDEX=LUT_INDEX, and keep Config_Done=0.
REQ-029 iSTART in DONE or ERROR SHALL clear LUT_INDEX, Config_Done, oCFG_ERR and the retry counter, then enter IDLE.
REQ-030 iSTART in any other state SHALL be ignored.
REQ-031 iSTART is sampled on every iCLK cycle; it SHALL NOT be gated by oI2C_EN.

Reset
REQ-032 On iRST_N=0 all outputs SHALL be 0: LUT_INDEX, oI2C_WDATA, oI2C_GO, oI2C_WR, Config_Done, oCFG_ERR, oERR_INDEX, oRDATA, oRDATA_VALID, oI2C_CLK, oI2C_EN.
REQ-033 On iRST_N=0 the FSM SHALL return to IDLE and all counters SHALL clear.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction immediately; the sequence SHALL restart from entry 0 after release.

Configuration
REQ-035 Macro I2C_CFG_VERIFY_EN defined: after each acked write, VRFY_ISSUE SHALL issue a read of the same sub-address.
REQ-036 With I2C_CFG_VERIFY_EN defined, the readback SHALL be compared in VRFY_WAIT with iLUT_DATA[7:0]; a mismatch or NACK SHALL count as a retry of the write.
REQ-037 Macro I2C_CFG_VERIFY_EN undefined: the VRFY states, the compare logic and the verify read SHALL be absent, and acked writes SHALL go straight to NEXT.

Structure
REQ-038 Package i2c_cfg_pkg SHALL hold the state enumeration, the DELAY_ADDR constant (8'hFF) and the ms-tick divisor function.
REQ-039 Sub-module i2c_cfg_tick SHALL contain the divider, oI2C_CLK, the oI2C_EN strobe and the 1 ms tick; the FSM SHALL reside in i2c_cfg_sequencer.

Verification
REQ-040 Defaults with an engine model that always acks: entries 0-1 are reads with oI2C_WR=0, entries 2-5 are writes; Config_Done=1 with LUT_INDEX=6, and there are two oRDATA_VALID pulses.
REQ-041 Entry 3 NACKed twice then acked: three attempts are made on entry 3; Config_Done=1 and oCFG_ERR=0.
REQ-042 Entry 4 NACKed permanently with MAX_RETRY=3: four attempts are made; oCFG_ERR=1 with oERR_INDEX=4; then iSTART restarts from index 0.
REQ-043 Entry 2={8'hFF,8'd5}: no oI2C_GO for entry 2, and at least 5 ms elapses before entry 3 issues.
REQ-044 iRST_N pulled low during WAIT of entry 3: all outputs are 0; after release the first oI2C_WDATA is {8'h42,LUT[0]}.
REQ-045 With I2C_CFG_VERIFY_EN defined and the entry-2 readback differing once: the write is reissued, the second verify matches, and the sequence completes.

Source files
------------

// File: rtl/i2c_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_cfg_pkg
// Purpose  : Shared state encoding, delay marker and ms-tick divisor helper
//            for the I2C configuration sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_ISSUE      = 4'd1,
        ST_WAIT       = 4'd2,
        ST_NEXT       = 4'd3,
        ST_DELAY      = 4'd4,
        ST_VRFY_ISSUE = 4'd5,
        ST_VRFY_WAIT  = 4'd6,
        ST_DONE       = 4'd7,
        ST_ERROR      = 4'd8
    } cfgState_t;

    localparam logic [7:0] DELAY_ADDR = 8'hFF;

    function automatic int msTickDiv(input int clkFreq);
        return (clkFreq / 1000 < 1) ? 1 : clkFreq / 1000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_cfg_tick.sv
`default_nettype none
// ============================================================================
// Module   : i2c_cfg_tick
// Purpose  : Generates the I2C work clock, the engine enable strobe (two
//            cycles after each work-clock fall) and a restartable 1 ms tick.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_cfg_tick
    import i2c_cfg_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int I2C_FREQ = 10_000
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iMS_CLR,
    output logic oI2C_CLK,
    output logic oI2C_EN,
    output logic oMS_TICK
);
    localparam int c_HALF   = (CLK_FREQ / I2C_FREQ) / 2 + 1;
    localparam int c_MS     = msTickDiv(CLK_FREQ);
    localparam int c_HALF_W = $clog2(c_HALF + 1);
    localparam int c_MS_W   = $clog2(c_MS + 1);
    localparam logic [c_HALF_W-1:0] c_HALF_LAST = c_HALF_W'(c_HALF - 1);
    localparam logic [c_MS_W-1:0]   c_MS_LAST   = c_MS_W'(c_MS - 1);

    logic [c_HALF_W-1:0] r_divCnt;
    logic [c_MS_W-1:0]   r_msCnt;
    logic                r_i2cClk, r_fall1, r_fall2, r_en, r_msTick;
    logic                w_halfEnd;

    assign w_halfEnd = (r_divCnt == c_HALF_LAST);
    assign oI2C_CLK  = r_i2cClk;
    assign oI2C_EN   = r_en;
    assign oMS_TICK  = r_msTick;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_divCnt <= '0;
            r_i2cClk <= 1'b0;
            r_fall1  <= 1'b0;
            r_fall2  <= 1'b0;
            r_en     <= 1'b0;
            r_msCnt  <= '0;
            r_msTick <= 1'b0;
        end else begin
            r_divCnt <= w_halfEnd ? '0 : r_divCnt + c_HALF_W'(1);
            if (w_halfEnd)
                r_i2cClk <= ~r_i2cClk;
            // r_fall1 rises together with the work-clock fall; strobe lands two cycles later
            r_fall1 <= w_halfEnd && r_i2cClk;
            r_fall2 <= r_fall1;
            r_en    <= r_fall2;

            if (iMS_CLR) begin
                r_msCnt  <= '0;
                r_msTick <= 1'b0;
            end else if (r_msCnt == c_MS_LAST) begin
                r_msCnt  <= '0;
                r_msTick <= 1'b1;
            end else begin
                r_msCnt  <= r_msCnt + c_MS_W'(1);
                r_msTick <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_cfg_sequencer
// Purpose  : Walks a register LUT, issuing reads/writes to an I2C engine with
//            retry, ms delays and optional write readback (I2C_CFG_VERIFY_EN).
// Revision : 1.0 - initial release
// ============================================================================
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int         CLK_FREQ   = 25_000_000,
    parameter int         I2C_FREQ   = 10_000,
    parameter int         LUT_SIZE   = 6,
    parameter int         READ_COUNT = 2,
    parameter logic [7:0] SLAVE_ADDR = 8'h42,
    parameter int         MAX_RETRY  = 3
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iSTART,
    output logic [7:0]  LUT_INDEX,
    input  logic [15:0] iLUT_DATA,
    output logic        oI2C_CLK,
    output logic        oI2C_EN,
    output logic [23:0] oI2C_WDATA,
    output logic        oI2C_GO,
    output logic        oI2C_WR,
    input  logic        iI2C_END,
    input  logic        iI2C_ACK,
    input  logic [7:0]  iI2C_RDATA,
    output logic        Config_Done,
    output logic        oCFG_ERR,
    output logic [7:0]  oERR_INDEX,
    output logic [7:0]  oRDATA,
    output logic        oRDATA_VALID
);
    localparam logic [7:0] c_LUT_SIZE   = 8'(LUT_SIZE);
    localparam logic [7:0] c_READ_COUNT = 8'(READ_COUNT);
    localparam logic [7:0] c_MAX_RETRY  = 8'(MAX_RETRY);

    cfgState_t   r_state;
    logic [7:0]  r_idx, r_retry, r_delayMs, r_errIdx, r_rdata;
    logic [23:0] r_wdata;
    logic        r_go, r_wr, r_done, r_err, r_rdValid;
    logic        w_msTick, w_isWrite, w_isDelay, w_msClr, w_startOk, w_lastTry;

    i2c_cfg_tick #(
        .CLK_FREQ (CLK_FREQ),
        .I2C_FREQ (I2C_FREQ)
    ) u_tick (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .iMS_CLR  (w_msClr),
        .oI2C_CLK (oI2C_CLK),
        .oI2C_EN  (oI2C_EN),
        .oMS_TICK (w_msTick)
    );

    assign w_isWrite = (r_idx >= c_READ_COUNT);
    assign w_isDelay = w_isWrite && (iLUT_DATA[15:8] == DELAY_ADDR);
    // Restart the ms timebase on DELAY entry so every waited ms is a full one
    assign w_msClr   = oI2C_EN && (r_state == ST_ISSUE) && w_isDelay && (iLUT_DATA[7:0] != 8'd0);
    assign w_startOk = iSTART && ((r_state == ST_DONE) || (r_state == ST_ERROR));
    assign w_lastTry = (r_retry >= c_MAX_RETRY);

`ifdef I2C_CFG_VERIFY_EN
    logic w_vrfyOk;
    assign w_vrfyOk = !iI2C_ACK && (iI2C_RDATA == iLUT_DATA[7:0]);
`endif

    assign LUT_INDEX    = r_idx;
    assign oI2C_WDATA   = r_wdata;
    assign oI2C_GO      = r_go;
    assign oI2C_WR      = r_wr;
    assign Config_Done  = r_done;
    assign oCFG_ERR     = r_err;
    assign oERR_INDEX   = r_errIdx;
    assign oRDATA       = r_rdata;
    assign oRDATA_VALID = r_rdValid;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state   <= ST_IDLE;
            r_idx     <= 8'd0;
            r_retry   <= 8'd0;
            r_delayMs <= 8'd0;
            r_errIdx  <= 8'd0;
            r_rdata   <= 8'd0;
            r_wdata   <= 24'd0;
            r_go      <= 1'b0;
            r_wr      <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= 1'b0;
            if (w_startOk) begin
                r_idx   <= 8'd0;
                r_retry <= 8'd0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
                r_state <= ST_IDLE;
            end else if (r_state == ST_DELAY) begin
                if (w_msTick) begin
                    if (r_delayMs <= 8'd1)
                        r_state <= ST_NEXT;
                    else
                        r_delayMs <= r_delayMs - 8'd1;
                end
            end else if (oI2C_EN) begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_idx < c_LUT_SIZE) begin
                            r_state <= ST_ISSUE;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                    ST_ISSUE: begin
                        if (w_isDelay) begin
                            r_delayMs <= iLUT_DATA[7:0];
                            r_state   <= (iLUT_DATA[7:0] == 8'd0) ? ST_NEXT : ST_DELAY;
                        end else begin
                            r_go    <= 1'b1;
                            r_wr    <= w_isWrite;
                            r_wdata <= {SLAVE_ADDR, iLUT_DATA};
                            // END low only counts once our GO has been visible to the engine
                            if (r_go && !iI2C_END)
                                r_state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (iI2C_END) begin
                            r_go <= 1'b0;
                            r_wr <= 1'b0;
                            if (!iI2C_ACK) begin
                                if (!w_isWrite) begin
                                    r_rdata   <= iI2C_RDATA;
                                    r_rdValid <= 1'b1;
                                    r_state   <= ST_NEXT;
                                end else begin
`ifdef I2C_CFG_VERIFY_EN
                                    r_state <= ST_VRFY_ISSUE;
`else
                                    r_state <= ST_NEXT;
`endif
                                end
                            end else if (w_lastTry) begin
                                r_err    <= 1'b1;
                                r_errIdx <= r_idx;
                                r_state  <= ST_ERROR;
                            end else begin
                                r_retry <= r_retry + 8'd1;
                                r_state <= ST_ISSUE;
                            end
                        end
                    end
`ifdef I2C_CFG_VERIFY_EN
                    ST_VRFY_ISSUE: begin
                        r_go    <= 1'b1;
                        r_wr    <= 1'b0;
                        r_wdata <= {SLAVE_ADDR, iLUT_DATA};
                        if (r_go && !iI2C_END)
                            r_state <= ST_VRFY_WAIT;
                    end
                    ST_VRFY_WAIT: begin
                        if (iI2C_END) begin
                            r_go <= 1'b0;
                            if (w_vrfyOk) begin
                                r_state <= ST_NEXT;
                            end else if (w_lastTry) begin
                                r_err    <= 1'b1;
                                r_errIdx <= r_idx;
                                r_state  <= ST_ERROR;
                            end else begin
                                r_retry <= r_retry + 8'd1;
                                r_state <= ST_ISSUE;
                            end
                        end
                    end
`endif
                    ST_NEXT: begin
                        r_idx   <= r_idx + 8'd1;
                        r_retry <= 8'd0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_cfg_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_cfg_sequencer
// Purpose  : Randomized bench with an I2C engine model and a transaction-level
//            reference model of the configuration sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_cfg_sequencer;
    localparam int         CLK_FREQ   = 100_000;
    localparam int         I2C_FREQ   = 10_000;
    localparam int         LUT_SIZE   = 6;
    localparam int         READ_COUNT = 2;
    localparam int         MAX_RETRY  = 3;
    localparam logic [7:0] SLAVE_ADDR = 8'h42;
    localparam int         MS_CYC     = CLK_FREQ / 1000;
    localparam int         PERM       = 255;
    localparam int         RUN_LIMIT  = 8000;
`ifdef I2C_CFG_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic        iCLK = 1'b0, iRST_N = 1'b0, iSTART = 1'b0;
    logic [7:0]  LUT_INDEX;
    logic [15:0] lutData;
    logic        oI2C_CLK, oI2C_EN, oI2C_GO, oI2C_WR;
    logic [23:0] oI2C_WDATA;
    logic        iI2C_END = 1'b1, iI2C_ACK = 1'b0;
    logic [7:0]  iI2C_RDATA = 8'h00;
    logic        Config_Done, oCFG_ERR, oRDATA_VALID;
    logic [7:0]  oERR_INDEX, oRDATA;

    i2c_cfg_sequencer #(
        .CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ), .LUT_SIZE(LUT_SIZE),
        .READ_COUNT(READ_COUNT), .SLAVE_ADDR(SLAVE_ADDR), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .LUT_INDEX(LUT_INDEX),
        .iLUT_DATA(lutData), .oI2C_CLK(oI2C_CLK), .oI2C_EN(oI2C_EN),
        .oI2C_WDATA(oI2C_WDATA), .oI2C_GO(oI2C_GO), .oI2C_WR(oI2C_WR),
        .iI2C_END(iI2C_END), .iI2C_ACK(iI2C_ACK), .iI2C_RDATA(iI2C_RDATA),
        .Config_Done(Config_Done), .oCFG_ERR(oCFG_ERR), .oERR_INDEX(oERR_INDEX),
        .oRDATA(oRDATA), .oRDATA_VALID(oRDATA_VALID)
    );

    always #5 iCLK = ~iCLK;

    logic [15:0] lut      [LUT_SIZE];
    logic [7:0]  rdTbl    [LUT_SIZE];
    int          nackPlan [LUT_SIZE];
    int          badPlan  [LUT_SIZE];
    int          nackLeft [LUT_SIZE];
    int          badLeft  [LUT_SIZE];

    always_comb begin
        lutData = 16'h0000;
        if (int'(LUT_INDEX) < LUT_SIZE)
            lutData = lut[int'(LUT_INDEX)];
    end

    int          cyc = 0;
    logic        actWr[$];
    logic [23:0] actWd[$];
    int          actStart[$], actEnd[$];
    logic [7:0]  actRd[$];
    logic        expWr[$];
    logic [23:0] expWd[$];
    int          expGap[$];
    logic [7:0]  expRd[$];
    logic        expErr;
    int          expErrIdx, expIdx;
    int          nCompared = 0, nMismatch = 0;

    always @(posedge iCLK) cyc <= cyc + 1;

    always @(negedge iCLK)
        if (oRDATA_VALID) actRd.push_back(oRDATA);

    // Engine model: one transaction per GO rising, END low for 20..60 cycles
    logic       engArmed = 1'b1, engAck, engVrfy;
    logic [7:0] engRd;
    int         engIdx, engDur;
    always begin
        @(posedge iCLK); #1;
        if (iRST_N && oI2C_GO && engArmed) begin
            engArmed = 1'b0;
            engIdx   = int'(LUT_INDEX);
            actWr.push_back(oI2C_WR);
            actWd.push_back(oI2C_WDATA);
            actStart.push_back(cyc);
            engAck = 1'b0;
            engRd  = 8'h00;
            if (engIdx < LUT_SIZE) begin
                engVrfy = !oI2C_WR && (engIdx >= READ_COUNT);
                if (engVrfy) begin
                    engRd = lut[engIdx][7:0];
                    if (badLeft[engIdx] > 0) begin
                        engRd = ~engRd;
                        badLeft[engIdx]--;
                    end
                end else begin
                    engRd = rdTbl[engIdx];
                    if (nackLeft[engIdx] > 0) begin
                        engAck = 1'b1;
                        if (nackLeft[engIdx] != PERM) nackLeft[engIdx]--;
                    end
                end
            end
            repeat (2) @(posedge iCLK);
            #1 iI2C_END = 1'b0;
            engDur = int'($urandom_range(20, 60));
            repeat (engDur) @(posedge iCLK);
            #1;
            iI2C_ACK   = engAck;
            iI2C_RDATA = engRd;
            iI2C_END   = 1'b1;
            actEnd.push_back(cyc);
        end else if (!oI2C_GO) begin
            engArmed = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] allOutputs();
        return {9'd0, LUT_INDEX, oI2C_WDATA, oI2C_GO, oI2C_WR, Config_Done, oCFG_ERR,
                oERR_INDEX, oRDATA, oRDATA_VALID, oI2C_CLK, oI2C_EN};
    endfunction

    // Expected transaction list derived from LUT contents and the fault plan
    task automatic buildModel();
        int gap;
        expWr.delete(); expWd.delete(); expGap.delete(); expRd.delete();
        expErr = 1'b0; expErrIdx = 0; expIdx = LUT_SIZE; gap = 0;
        for (int i = 0; i < LUT_SIZE; i++) begin
            logic        wr, ok;
            logic [23:0] wd;
            int          nk, bd, tries;
            wr = (i >= READ_COUNT);
            wd = {SLAVE_ADDR, lut[i]};
            if (wr && lut[i][15:8] == 8'hFF) begin
                gap += int'(lut[i][7:0]) * MS_CYC;
                continue;
            end
            nk = nackPlan[i]; bd = badPlan[i]; tries = 0; ok = 1'b0;
            forever begin
                expWr.push_back(wr); expWd.push_back(wd); expGap.push_back(gap);
                gap = 0;
                if (nk > 0) begin
                    ok = 1'b0;
                    if (nk != PERM) nk--;
                end else if (wr && VERIFY) begin
                    expWr.push_back(1'b0); expWd.push_back(wd); expGap.push_back(0);
                    ok = (bd == 0);
                    if (bd > 0) bd--;
                end else begin
                    ok = 1'b1;
                end
                if (ok || tries == MAX_RETRY) break;
                tries++;
            end
            if (!ok) begin
                expErr = 1'b1; expErrIdx = i; expIdx = i;
                return;
            end
            if (!wr) expRd.push_back(rdTbl[i]);
        end
    endtask

    task automatic setDefaults();
        for (int i = 0; i < LUT_SIZE; i++) begin
            lut[i]      = {8'($urandom_range(0, 254)), 8'($urandom)};
            rdTbl[i]    = 8'($urandom);
            nackPlan[i] = 0;
            badPlan[i]  = 0;
        end
    endtask

    task automatic arm();
        for (int i = 0; i < LUT_SIZE; i++) begin
            nackLeft[i] = nackPlan[i];
            badLeft[i]  = badPlan[i];
        end
        actWr.delete(); actWd.delete(); actStart.delete(); actEnd.delete(); actRd.delete();
        buildModel();
    endtask

    task automatic restart();
        @(negedge iCLK) iSTART = 1'b1;
        @(negedge iCLK) iSTART = 1'b0;
    endtask

    task automatic waitAndCheck(input string tag);
        int k, n;
        k = 0;
        while (!(Config_Done || oCFG_ERR) && k < RUN_LIMIT) begin
            @(negedge iCLK);
            k++;
        end
        chk({tag, "_finished"}, 64'(k < RUN_LIMIT), 64'd1);
        repeat (3) @(negedge iCLK);
        chk({tag, "_done"}, 64'(Config_Done), 64'(!expErr));
        chk({tag, "_err"}, 64'(oCFG_ERR), 64'(expErr));
        if (expErr) chk({tag, "_errIdx"}, 64'(oERR_INDEX), 64'(expErrIdx));
        chk({tag, "_index"}, 64'(LUT_INDEX), 64'(expIdx));
        chk({tag, "_ntxn"}, 64'(actWd.size()), 64'(expWd.size()));
        n = (actWd.size() < expWd.size()) ? actWd.size() : expWd.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_txn%0d", tag, i), {39'd0, actWr[i], actWd[i]}, {39'd0, expWr[i], expWd[i]});
            if (expGap[i] > 0 && i > 0 && i - 1 < actEnd.size())
                chk($sformatf("%s_gap%0d", tag, i), 64'((actStart[i] - actEnd[i-1]) >= expGap[i]), 64'd1);
        end
        chk({tag, "_nrd"}, 64'(actRd.size()), 64'(expRd.size()));
        n = (actRd.size() < expRd.size()) ? actRd.size() : expRd.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_rd%0d", tag, i), 64'(actRd[i]), 64'(expRd[i]));
    endtask

    initial begin
        int k;
        setDefaults();
        arm();
        repeat (3) @(negedge iCLK);
        chk("reset_outputs", allOutputs(), 64'd0);
        iRST_N = 1'b1;
        waitAndCheck("allack");

        setDefaults(); nackPlan[3] = 2; nackPlan[5] = MAX_RETRY;
        arm(); restart();
        waitAndCheck("nack_retry");

        setDefaults(); nackPlan[4] = PERM;
        arm(); restart();
        waitAndCheck("nack_perm");

        setDefaults();
        arm(); restart();
        chk("restart_index", 64'(LUT_INDEX), 64'd0);
        waitAndCheck("rerun");

        setDefaults(); lut[2] = {8'hFF, 8'd5};
        arm(); restart();
        waitAndCheck("delay5ms");

        setDefaults();
        arm(); restart();
        k = 0;
        while (!(LUT_INDEX == 8'd3 && oI2C_GO && !iI2C_END) && k < RUN_LIMIT) begin
            @(negedge iCLK);
            k++;
        end
        chk("midrst_reach", 64'(k < RUN_LIMIT), 64'd1);
        iRST_N = 1'b0;
        @(negedge iCLK);
        chk("midrst_outputs", allOutputs(), 64'd0);
        repeat (80) @(negedge iCLK);
        actWr.delete(); actWd.delete(); actStart.delete(); actEnd.delete(); actRd.delete();
        iRST_N = 1'b1;
        waitAndCheck("midrst");
        if (actWd.size() > 0)
            chk("midrst_first_wdata", 64'(actWd[0]), 64'({SLAVE_ADDR, lut[0]}));

        for (int r = 0; r < 4; r++) begin
            setDefaults();
            for (int i = 0; i < LUT_SIZE; i++) begin
                if ($urandom_range(0, 3) == 0) nackPlan[i] = int'($urandom_range(1, 3));
                if ($urandom_range(0, 9) == 0) nackPlan[i] = PERM;
                if (i >= READ_COUNT && $urandom_range(0, 4) == 0)
                    lut[i] = {8'hFF, 8'($urandom_range(0, 3))};
            end
            arm(); restart();
            waitAndCheck($sformatf("rand%0d", r));
        end

`ifdef I2C_CFG_VERIFY_EN
        setDefaults(); badPlan[2] = 1;
        arm(); restart();
        waitAndCheck("verify_retry");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
`default_nettype wire
